// File: rtl/regfile_scoreboard.sv
// Hazard scoreboard between decode and the banked register file: counts outstanding writes per (bank, reg).
// Optional SCOREBOARD_STATS_EN adds stall/hazard statistics counters.
module regfile_scoreboard #(
  parameter int unsigned BANK_W    = 2,
  parameter int unsigned CNT_W     = 2,
  parameter int unsigned WB_BYPASS = 1
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              issue_valid_in,
  input  logic [BANK_W-1:0] issue_bank_in,
  input  logic [4:0]        issue_rsa_addr_in,
  input  logic [4:0]        issue_rsb_addr_in,
  input  logic              issue_use_rsb_in,
  input  logic              issue_rd_we_in,
  input  logic [4:0]        issue_rd_addr_in,
  input  logic [BANK_W-1:0] issue_wb_bank_in,
  input  logic              stall_in,
  input  logic              flush_in,
  input  logic              wb_valid_in,
  input  logic [4:0]        wb_reg_addr_in,
  input  logic [BANK_W-1:0] wb_regf_sel_in,
  output logic              stall_out,
  output logic              issue_ack_out,
  output logic              idle_out
`ifdef SCOREBOARD_STATS_EN
  ,
  output logic [15:0]       stall_cycles_out,
  output logic [15:0]       hazard_raw_out
`endif
);

  localparam int unsigned NUM_BANKS = 1 << BANK_W;
  localparam int unsigned NUM_REGS  = 32;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt     [NUM_BANKS][NUM_REGS];
  logic [CNT_W-1:0] cnt_nxt [NUM_BANKS][NUM_REGS];
  logic             idle_nxt;

  logic [CNT_W-1:0] rsa_cnt, rsb_cnt, rd_cnt;
  logic             wb_live, byp_a, byp_b, hz_a, hz_b, hz_w, inc_en;

  assign rsa_cnt = cnt[issue_bank_in][issue_rsa_addr_in];
  assign rsb_cnt = cnt[issue_bank_in][issue_rsb_addr_in];
  assign rd_cnt  = cnt[issue_wb_bank_in][issue_rd_addr_in];
  assign wb_live = wb_valid_in && (wb_reg_addr_in != 5'd0);

  // A writeback retiring the last pending write lets the reader through in the same cycle.
  assign byp_a = (WB_BYPASS != 0) && wb_live && (wb_regf_sel_in == issue_bank_in) &&
                 (wb_reg_addr_in == issue_rsa_addr_in) && (rsa_cnt == CNT_ONE);
  assign byp_b = (WB_BYPASS != 0) && wb_live && (wb_regf_sel_in == issue_bank_in) &&
                 (wb_reg_addr_in == issue_rsb_addr_in) && (rsb_cnt == CNT_ONE);

  assign hz_a = (rsa_cnt != '0) && !byp_a;
  assign hz_b = issue_use_rsb_in && (rsb_cnt != '0) && !byp_b;
  assign hz_w = issue_rd_we_in && (issue_rd_addr_in != 5'd0) && (rd_cnt == CNT_MAX);

  assign stall_out     = issue_valid_in && (hz_a || hz_b || hz_w);
  assign issue_ack_out = issue_valid_in && !stall_out && !stall_in && !flush_in;
  assign inc_en        = issue_ack_out && issue_rd_we_in && (issue_rd_addr_in != 5'd0);

  // Per-entry next count; simultaneous issue and retire on one entry cancel out.
  always_comb begin
    idle_nxt = 1'b1;
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int r = 0; r < NUM_REGS; r++) begin : g_entry
        logic inc, dec;
        inc = inc_en && (issue_wb_bank_in == BANK_W'(b)) && (issue_rd_addr_in == 5'(r));
        dec = wb_live && (wb_regf_sel_in == BANK_W'(b)) && (wb_reg_addr_in == 5'(r)) &&
              (cnt[b][r] != '0);
        cnt_nxt[b][r] = cnt[b][r];
        if (inc && !dec) begin
          cnt_nxt[b][r] = cnt[b][r] + CNT_ONE;
        end else if (dec && !inc) begin
          cnt_nxt[b][r] = cnt[b][r] - CNT_ONE;
        end
        if (cnt_nxt[b][r] != '0) begin
          idle_nxt = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset_in || flush_in) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        for (int r = 0; r < NUM_REGS; r++) begin
          cnt[b][r] <= '0;
        end
      end
      idle_out <= 1'b1;
    end else begin
      cnt      <= cnt_nxt;
      idle_out <= idle_nxt;
    end
  end

`ifdef SCOREBOARD_STATS_EN
  logic stalled_q;

  // Saturating statistics; stalled_q marks an instruction that has waited on a hazard.
  always_ff @(posedge clk_in) begin
    if (!reset_in || flush_in) begin
      stall_cycles_out <= 16'd0;
      hazard_raw_out   <= 16'd0;
      stalled_q        <= 1'b0;
    end else begin
      if (stall_out && (stall_cycles_out != 16'hFFFF)) begin
        stall_cycles_out <= stall_cycles_out + 16'd1;
      end
      if (issue_ack_out && stalled_q && (hazard_raw_out != 16'hFFFF)) begin
        hazard_raw_out <= hazard_raw_out + 16'd1;
      end
      if (issue_ack_out) begin
        stalled_q <= 1'b0;
      end else if (stall_out) begin
        stalled_q <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios then random traffic against a counting model.
module tb_regfile_scoreboard;

  localparam int CMAX = 3;

  logic       clk_in = 1'b0;
  logic       reset_in, issue_valid_in, issue_use_rsb_in, issue_rd_we_in;
  logic [1:0] issue_bank_in, issue_wb_bank_in, wb_regf_sel_in;
  logic [4:0] issue_rsa_addr_in, issue_rsb_addr_in, issue_rd_addr_in, wb_reg_addr_in;
  logic       stall_in, flush_in, wb_valid_in;
  logic       stall_out, issue_ack_out, idle_out;
`ifdef SCOREBOARD_STATS_EN
  logic [15:0] stall_cycles_out, hazard_raw_out;
`endif

  regfile_scoreboard dut (
    .clk_in(clk_in), .reset_in(reset_in),
    .issue_valid_in(issue_valid_in), .issue_bank_in(issue_bank_in),
    .issue_rsa_addr_in(issue_rsa_addr_in), .issue_rsb_addr_in(issue_rsb_addr_in),
    .issue_use_rsb_in(issue_use_rsb_in), .issue_rd_we_in(issue_rd_we_in),
    .issue_rd_addr_in(issue_rd_addr_in), .issue_wb_bank_in(issue_wb_bank_in),
    .stall_in(stall_in), .flush_in(flush_in), .wb_valid_in(wb_valid_in),
    .wb_reg_addr_in(wb_reg_addr_in), .wb_regf_sel_in(wb_regf_sel_in),
    .stall_out(stall_out), .issue_ack_out(issue_ack_out), .idle_out(idle_out)
`ifdef SCOREBOARD_STATS_EN
    , .stall_cycles_out(stall_cycles_out), .hazard_raw_out(hazard_raw_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  int n_chk = 0;
  int n_fail = 0;
  int m [4][32];
  int sc = 0, hr = 0;
  bit sflag = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_idle();
    for (int b = 0; b < 4; b++)
      for (int r = 0; r < 32; r++)
        if (m[b][r] != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit src_hazard(input int bank, input int addr);
    bit retire;
    retire = wb_valid_in && wb_reg_addr_in != 0 && int'(wb_regf_sel_in) == bank &&
             int'(wb_reg_addr_in) == addr && m[bank][addr] == 1;
    return m[bank][addr] != 0 && !retire;
  endfunction

  task automatic clear_in();
    issue_valid_in = 0; issue_bank_in = 0; issue_rsa_addr_in = 0; issue_rsb_addr_in = 0;
    issue_use_rsb_in = 0; issue_rd_we_in = 0; issue_rd_addr_in = 0; issue_wb_bank_in = 0;
    stall_in = 0; flush_in = 0; wb_valid_in = 0; wb_reg_addr_in = 0; wb_regf_sel_in = 0;
  endtask

  task automatic issue(input int bank, input int rsa, input bit we, input int rd, input int wbank);
    issue_valid_in = 1; issue_bank_in = 2'(bank); issue_rsa_addr_in = 5'(rsa);
    issue_use_rsb_in = 0; issue_rsb_addr_in = 0;
    issue_rd_we_in = we; issue_rd_addr_in = 5'(rd); issue_wb_bank_in = 2'(wbank);
  endtask

  task automatic wb(input bit v, input int addr, input int bank);
    wb_valid_in = v; wb_reg_addr_in = 5'(addr); wb_regf_sel_in = 2'(bank);
  endtask

  // Check combinational outputs, clock once, advance the model, check registered outputs.
  task automatic cycle();
    bit es, ea, dec;
    int wb_b, wb_r, rd_b, rd_r;
    #2;
    es = issue_valid_in && (src_hazard(int'(issue_bank_in), int'(issue_rsa_addr_in)) ||
         (issue_use_rsb_in && src_hazard(int'(issue_bank_in), int'(issue_rsb_addr_in))) ||
         (issue_rd_we_in && issue_rd_addr_in != 0 &&
          m[issue_wb_bank_in][issue_rd_addr_in] == CMAX));
    ea = issue_valid_in && !es && !stall_in && !flush_in;
    check("stall_out", stall_out, es);
    check("issue_ack_out", issue_ack_out, ea);
    @(posedge clk_in);
    if (!reset_in || flush_in) begin
      foreach (m[b, r]) m[b][r] = 0;
      sc = 0; hr = 0; sflag = 0;
    end else begin
      wb_b = int'(wb_regf_sel_in); wb_r = int'(wb_reg_addr_in);
      rd_b = int'(issue_wb_bank_in); rd_r = int'(issue_rd_addr_in);
      dec = wb_valid_in && wb_r != 0 && m[wb_b][wb_r] > 0;
      if (dec) m[wb_b][wb_r]--;
      if (ea && issue_rd_we_in && rd_r != 0) m[rd_b][rd_r]++;
      if (es && sc < 16'hFFFF) sc++;
      if (ea && sflag && hr < 16'hFFFF) hr++;
      if (ea) sflag = 0; else if (es) sflag = 1;
    end
    #1;
    check("idle_out", idle_out, model_idle());
`ifdef SCOREBOARD_STATS_EN
    check("stall_cycles_out", stall_cycles_out, sc);
    check("hazard_raw_out", hazard_raw_out, hr);
`endif
  endtask

  initial begin
    foreach (m[b, r]) m[b][r] = 0;
    clear_in();
    // Reset held two cycles with a zero-address instruction presented
    reset_in = 0;
    issue(0, 0, 0, 0, 0);
    #1; check("rst_stall", stall_out, 0);
    cycle();
    cycle();
    check("rst_idle", idle_out, 1);
    reset_in = 1;
    #1; check("rst_ack", issue_ack_out, 1);
    cycle();

    // RAW on r5 bank1 resolved by bypassed writeback
    issue(1, 0, 1, 5, 1); cycle();
    issue(1, 5, 0, 0, 0);
    #1; check("raw_stall", stall_out, 1);
    cycle();
    wb(1, 5, 1);
    #1; check("raw_byp_stall", stall_out, 0); check("raw_byp_ack", issue_ack_out, 1);
    cycle();
    check("raw_idle", idle_out, 1);
    wb(0, 0, 0);

    // Bank isolation and r0 writes
    issue(1, 0, 1, 5, 1); cycle();
    issue(0, 5, 0, 0, 0);
    #1; check("bank_iso_stall", stall_out, 0);
    cycle();
    issue_valid_in = 0; wb(1, 5, 1); cycle();
    wb(0, 0, 0); issue(0, 0, 1, 0, 2); cycle();
    check("r0_idle", idle_out, 1);

    // Saturation on r7 bank0
    issue(0, 0, 1, 7, 0);
    repeat (3) cycle();
    #1; check("sat_stall", stall_out, 1);
    cycle();
    wb(1, 7, 0); cycle();
    wb(0, 0, 0);
    #1; check("sat_ack", issue_ack_out, 1);
    cycle();
    issue_valid_in = 0; wb(1, 7, 0);
    repeat (3) cycle();
    check("sat_drain_idle", idle_out, 1);
    wb(0, 0, 0);

    // Simultaneous issue and retire on r9, then flush and a late writeback
    issue(0, 0, 1, 9, 0); cycle();
    wb(1, 9, 0); cycle();
    wb(0, 0, 0); issue(0, 9, 0, 0, 0);
    #1; check("simul_stall", stall_out, 1);
    cycle();
    issue_valid_in = 0; flush_in = 1; cycle();
    check("flush_idle", idle_out, 1);
    flush_in = 0; wb(1, 9, 0); cycle();
    check("late_wb_idle", idle_out, 1);
    wb(0, 0, 0); issue(0, 9, 0, 0, 0);
    #1; check("post_flush_stall", stall_out, 0);
    cycle();

    // Downstream stall blocks ack and counter increment
    issue(2, 0, 1, 3, 2); stall_in = 1;
    #1; check("stall_in_ack", issue_ack_out, 0);
    cycle();
    check("stall_in_idle", idle_out, 1);
    stall_in = 0;

    // Four hazard-stall cycles on r4
    issue_valid_in = 0; flush_in = 1; cycle(); flush_in = 0;
    issue(3, 0, 1, 4, 3); cycle();
    issue(3, 4, 0, 0, 0);
    repeat (4) cycle();
`ifdef SCOREBOARD_STATS_EN
    check("stats_stall_cycles", stall_cycles_out, 4);
`endif
    wb(1, 4, 3); cycle();
`ifdef SCOREBOARD_STATS_EN
    check("stats_hazard_raw", hazard_raw_out, 1);
`endif
    clear_in(); cycle();

    // Random traffic over a small address space to provoke hazards
    for (int i = 0; i < 1500; i++) begin
      reset_in          = ($urandom_range(99) != 0);
      flush_in          = ($urandom_range(39) == 0);
      stall_in          = ($urandom_range(4) == 0);
      issue_valid_in    = ($urandom_range(3) != 0);
      issue_bank_in     = 2'($urandom_range(3));
      issue_rsa_addr_in = 5'($urandom_range(3));
      issue_rsb_addr_in = 5'($urandom_range(3));
      issue_use_rsb_in  = 1'($urandom_range(1));
      issue_rd_we_in    = ($urandom_range(3) != 0);
      issue_rd_addr_in  = 5'($urandom_range(3));
      issue_wb_bank_in  = 2'($urandom_range(3));
      wb_valid_in       = ($urandom_range(2) != 0);
      wb_reg_addr_in    = 5'($urandom_range(3));
      wb_regf_sel_in    = 2'($urandom_range(3));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Hazard scheduler between the decode stage and the banked main-core register file.
- Tracks outstanding writes per (bank, register) and stalls issue while a source operand or destination slot is pending.
- Advances issue only when operands are safe, and retires pending writes on writeback.
- Sits beside decode; its stall_out feeds the decode stage stall input.

Parameters:
- BANK_W, 2, bank-select bits used (NUM_BANKS = 2^BANK_W); upper bank-select bits are ignored.
- CNT_W, 2, width of the per-entry outstanding-write counter.
- WB_BYPASS, 1, 1 = same-cycle writeback that clears an entry resolves a read hazard in that cycle (write-before-read regfile).

Ports:
- clk_in  in  1  clock
- reset_in  in  1  reset, synchronous, active-low
- issue_valid_in  in  1  decode holds an instruction to issue
- issue_bank_in  in  BANK_W  source bank select
- issue_rsa_addr_in  in  5  RSA address
- issue_rsb_addr_in  in  5  RSB address
- issue_use_rsb_in  in  1  RSB is read (0 when the immediate is used)
- issue_rd_we_in  in  1  instruction writes RD
- issue_rd_addr_in  in  5  RD address
- issue_wb_bank_in  in  BANK_W  RD bank
- stall_in  in  1  downstream stall
- flush_in  in  1  pipeline flush; discard all pending entries
- wb_valid_in  in  1  writeback occurring
- wb_reg_addr_in  in  5  writeback register
- wb_regf_sel_in  in  BANK_W  writeback bank
- stall_out  out  1  hazard stall to decode, combinational
- issue_ack_out  out  1  instruction accepted this cycle
- idle_out  out  1  no outstanding writes, registered

Behaviour:
- State: NUM_BANKS*32 counters cnt[bank][reg], each CNT_W bits; register 0 of every bank is never tracked and reads as 0.
- Reset (reset_in=0 at a clk_in edge): all counters 0, idle_out=1. Reset overrides flush, issue and writeback in the same cycle.
- Hazard terms:
  - hz_a = cnt[issue_bank][rsa] != 0
  - hz_b = issue_use_rsb_in & cnt[issue_bank][rsb] != 0
  - hz_w = issue_rd_we_in & rd!=0 & cnt[wb_bank][rd] == max (saturation guard)
  - With WB_BYPASS=1, a source term is masked when wb_valid_in hits the same entry and that entry's cnt==1.
- stall_out = issue_valid_in & (hz_a | hz_b | hz_w). It is 0 when issue_valid_in=0.
- issue_ack_out = issue_valid_in & ~stall_out & ~stall_in & ~flush_in.
- Update rule per entry on each edge: inc = issue_ack_out & issue_rd_we_in & rd!=0 & entry hit; dec = wb_valid_in & wb_reg_addr_in!=0 & entry hit & cnt!=0.
  - inc&dec: unchanged.
  - inc only: +1.
  - dec only: -1.
- A writeback to an entry with cnt==0 is ignored (no underflow). Late writebacks after a flush are absorbed this way.
- flush_in=1: all counters cleared next edge. Issue is suppressed that cycle, and any writeback that cycle is discarded.
- idle_out is registered: 1 when all counters are 0 after the edge.
- Latency:
  - Hazard detection is zero-cycle (same cycle as issue_valid_in).
  - Pending state is visible to the next issue one cycle after ack.
  - A writeback releases a stalled reader in the same cycle with WB_BYPASS=1, or the next cycle with WB_BYPASS=0.
- Issue and writeback to different banks with the same register number are independent.

Optional Feature:
- Macro: SCOREBOARD_STATS_EN.
- When defined, adds outputs stall_cycles_out[15:0] and hazard_raw_out[15:0].
  - stall_cycles_out counts cycles with stall_out=1.
  - hazard_raw_out counts acked instructions that previously stalled at least once.
  - Both counters saturate at 16'hFFFF, reset to 0, and are cleared by flush_in.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset: hold reset_in=0 2 cycles with issue_valid_in=1 and all addresses 0 -> stall_out=0, idle_out=1, issue_ack_out=1 after release.
- RAW: ack write r5 bank1; next cycle issue rsa=5 bank1 -> stall_out=1. Then wb r5 bank1 -> with WB_BYPASS=1 stall_out=0 that cycle and ack=1; idle_out=1 next cycle.
- Bank isolation and r0: pending r5 bank1; issue rsa=5 bank0 -> no stall. Issue rd=0 with rd_we -> no counter change, idle_out stays 1.
- Saturation (CNT_W=2): ack 3 writes to r7 with no wb; 4th write to r7 -> stall_out=1. One wb to r7 -> ack next attempt.
- Simultaneous: ack write r9 in the same cycle as wb r9 with cnt=1 -> cnt stays 1 and a subsequent read of r9 stalls. Flush -> idle_out=1 next cycle; a late wb r9 is ignored and cnt stays 0.
- Stall priority: stall_in=1 with no hazard -> issue_ack_out=0, no counter increment. With SCOREBOARD_STATS_EN, 4 hazard-stall cycles -> stall_cycles_out=4.
